// File: rtl/call_initiator.sv
// Caller side of a start/done call protocol: accepts a request, pulses start to a
// callee, waits for its done (ignoring a stale-high done), and returns the result.
module call_initiator #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_timeout,
  output logic                 callee_start,
  output logic [WIDTH-1:0]     callee_a,
  output logic [WIDTH-1:0]     callee_b,
  input  logic [WIDTH-1:0]     callee_result,
  input  logic                 callee_done,
  output logic [CNT_WIDTH-1:0] call_count,
  output logic [1:0]           dbg_state
);

  // Handshakes: a request transfers on a rising clk edge where req_valid && req_ready;
  // a response transfers on a rising edge where rsp_valid && rsp_ready. rsp_* hold
  // stable while rsp_valid && !rsp_ready.

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_LOW  = 2'd1;
  localparam logic [1:0] WAIT_HIGH = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [TW-1:0] tmo;

  assign req_ready = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tmo          <= '0;
      callee_start <= 1'b0;
      callee_a     <= '0;
      callee_b     <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_timeout  <= 1'b0;
      call_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            callee_a     <= req_a;
            callee_b     <= req_b;
            callee_start <= 1'b1;
            tmo          <= '0;
            state        <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          // done is still high from the previous call until the callee picks up start
          callee_start <= 1'b0;
          tmo          <= tmo + TW'(1);
          if (tmo == TMO_LAST) begin
            rsp_result  <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (!callee_done) begin
            state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          tmo <= tmo + TW'(1);
          // completion takes priority over a timeout landing in the same cycle
          if (callee_done) begin
            rsp_result  <= callee_result;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            call_count  <= call_count + CNT_WIDTH'(1);
            state       <= RESP;
          end else if (tmo == TMO_LAST) begin
            rsp_result  <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_call_initiator.sv
// Bench for call_initiator: a 3-state callee model with optional delay / deafness,
// a driver issuing directed calls, and a queue-based response scoreboard.
module tb_call_initiator;
  localparam int WIDTH = 32;
  localparam int TMO   = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_timeout;
  logic             callee_start;
  logic [WIDTH-1:0] callee_a;
  logic [WIDTH-1:0] callee_b;
  logic [WIDTH-1:0] callee_result = '0;
  logic             callee_done = 1'b0;
  logic [CW-1:0]    call_count;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  call_initiator #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_timeout(rsp_timeout), .callee_start(callee_start), .callee_a(callee_a),
    .callee_b(callee_b), .callee_result(callee_result), .callee_done(callee_done),
    .call_count(call_count), .dbg_state(dbg_state)
  );

  // Callee: start seen -> done falls next edge -> rises (1 + delay) edges later.
  logic       cal_ignore = 1'b0;
  int         cal_delay = 0;
  logic [1:0] cal_st = 2'd0;
  int         cal_cnt = 0;
  always @(posedge clk) begin
    case (cal_st)
      2'd0: if (callee_start && !cal_ignore) begin cal_st <= 2'd1; cal_cnt <= cal_delay; end
      2'd1: begin callee_done <= 1'b0; callee_result <= callee_a; cal_st <= 2'd2; end
      2'd2: if (cal_cnt == 0) begin callee_done <= 1'b1; cal_st <= 2'd0; end
            else cal_cnt <= cal_cnt - 1;
      default: cal_st <= 2'd0;
    endcase
  end

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_tmo_q[$];
  logic [CW-1:0]    exp_cnt_q[$];
  logic [CW-1:0]    exp_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: response handshake and callee argument stability.
  logic             prev_busy = 1'b0;
  logic             prev_rst = 1'b1;
  logic [WIDTH-1:0] prev_a = '0;
  logic [WIDTH-1:0] prev_b = '0;
  logic [WIDTH-1:0] m_res;
  logic             m_tmo;
  logic [CW-1:0]    m_cnt;
  always @(negedge clk) begin
    #1;
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
      else begin
        m_res = exp_q.pop_front();
        m_tmo = exp_tmo_q.pop_front();
        m_cnt = exp_cnt_q.pop_front();
        check("rsp_result", rsp_result, m_res);
        check("rsp_timeout", rsp_timeout, m_tmo);
        check("call_count", call_count, m_cnt);
      end
    end
    if (!reset && !prev_rst && prev_busy) begin
      check("callee_a_stable", callee_a, prev_a);
      check("callee_b_stable", callee_b, prev_b);
    end
    prev_busy = !req_ready;
    prev_rst  = reset;
    prev_a    = callee_a;
    prev_b    = callee_b;
  end

  // Issue one request; returns at a negedge with the DUT back in IDLE.
  task automatic do_call(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ign, input int dly, input logic hold,
                         input logic [WIDTH-1:0] exp_res, input logic exp_tmo,
                         input int exp_lat);
    int n;
    int k;
    cal_ignore = ign;
    cal_delay  = dly;
    rsp_ready  = !hold;
    @(negedge clk);
    req_a = a; req_b = b; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("req_accept_bound", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    if (!exp_tmo) exp_cnt = exp_cnt + CW'(1);
    exp_q.push_back(exp_res);
    exp_tmo_q.push_back(exp_tmo);
    exp_cnt_q.push_back(exp_cnt);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 40) begin
      if (k == 0) check("start_high", callee_start, 64'd1);
      if (k == 1) check("start_pulse_len", callee_start, 64'd0);
      @(negedge clk);
      k++;
    end
    check("rsp_latency", k, exp_lat);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        check("hold_valid", rsp_valid, 64'd1);
        check("hold_result", rsp_result, exp_res);
        check("hold_req_ready", req_ready, 64'd0);
        @(negedge clk);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("req_ready_after_rsp", req_ready, 64'd1);
    check("rsp_valid_cleared", rsp_valid, 64'd0);
    cal_ignore = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", dbg_state, 64'd0);
    check("reset_req_ready", req_ready, 64'd1);
    check("reset_rsp_valid", rsp_valid, 64'd0);
    check("reset_start", callee_start, 64'd0);
    check("reset_count", call_count, 64'd0);

    // Basic call, done low at first start.
    do_call(32'd5, 32'd9, 1'b0, 0, 1'b0, 32'd5, 1'b0, 4);
    check("count_after_first", call_count, 64'd1);

    // Back-to-back calls with done left high between them.
    do_call(32'd7, 32'd1, 1'b0, 0, 1'b0, 32'd7, 1'b0, 4);
    do_call(32'd3, 32'd2, 1'b0, 0, 1'b0, 32'd3, 1'b0, 4);

    // Downstream stall for 10 cycles.
    do_call(32'hDEAD_BEEF, 32'h1234, 1'b0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 4);

    // Deaf callee: timeout 8 cycles after WAIT_LOW entry.
    do_call(32'd11, 32'd12, 1'b1, 0, 1'b0, 32'd0, 1'b1, 8);
    check("count_after_timeout", call_count, 64'd4);

    // Done seen on the last allowed cycle wins; one cycle later is a timeout.
    do_call(32'h55, 32'h66, 1'b0, 4, 1'b0, 32'h55, 1'b0, 8);
    do_call(32'h77, 32'h88, 1'b0, 5, 1'b0, 32'd0, 1'b1, 8);
    repeat (4) @(negedge clk);

    // Reset while waiting for done to rise.
    cal_delay = 0; cal_ignore = 1'b0;
    req_a = 32'h99; req_b = 32'h42; req_valid = 1'b1;
    check("rst_case_ready", req_ready, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("in_wait_high", dbg_state, 64'd2);
    reset = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_rsp_timeout", rsp_timeout, 64'd0);
    check("rst_start", callee_start, 64'd0);
    check("rst_callee_a", callee_a, 64'd0);
    check("rst_callee_b", callee_b, 64'd0);
    check("rst_count", call_count, 64'd0);
    check("rst_state", dbg_state, 64'd0);
    reset = 1'b0;
    exp_cnt = '0;
    repeat (3) @(negedge clk);

    // 2^CW + 1 completions wrap the counter to 1.
    for (int i = 0; i < 17; i++)
      do_call(32'(i * 13 + 1), 32'(i * 7 + 100), 1'b0, 0, 1'b0, 32'(i * 13 + 1), 1'b0, 4);
    check("count_wrap", call_count, 64'd1);

    repeat (4) @(negedge clk);
    check("pending_rsp", exp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
